// File: rtl/shift_crc_reg.sv
// ---------------------------------------------------------------------------
// shift_crc_reg
//
// Purpose:
//   Generic-width shift register with parallel load and a CRC/LFSR step mode.
//   It is used in the memory-access datapath. It serialises words and computes
//   a running CRC over data moving between the controller and memory.
//   A frame step counter raises a one-cycle done pulse every FRAME_LEN
//   enabled steps.
//
// Parameters:
//   WIDTH     - register width in bits (>= 2)
//   POLY      - CRC polynomial without the implicit x^WIDTH term
//   INIT      - value q takes on reset
//   FRAME_LEN - enabled steps per frame (1 .. 2**CNT_W-1)
//   CNT_W     - width of the step counter
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   synchronous reset, active low
//   load     in   parallel load strobe (wins over a simultaneous step)
//   load_val in   value loaded into q
//   en       in   step enable
//   mode     in   00 hold, 01 shift left, 10 shift right, 11 CRC step
//   din      in   serial data input
//   q        out  register contents (registered)
//   pop      out  bit shifted out on the last step (registered)
//   cnt      out  steps taken in the current frame (registered)
//   done     out  one-cycle pulse when a frame completes (registered)
// ---------------------------------------------------------------------------
module shift_crc_reg #(
  parameter int unsigned       WIDTH     = 8,
  parameter logic [WIDTH-1:0]  POLY      = WIDTH'('h07),
  parameter logic [WIDTH-1:0]  INIT      = '0,
  parameter int unsigned       FRAME_LEN = 8,
  parameter int unsigned       CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             din,
  output logic [WIDTH-1:0] q,
  output logic             pop,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_LEFT  = 2'b01,
    MODE_RIGHT = 2'b10,
    MODE_CRC   = 2'b11
  } mode_e;

  // Counter value of the final step in a frame.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             pop_q, pop_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic             step;
  logic             crc_fb;
  mode_e            mode_sel;

  assign mode_sel = mode_e'(mode);
  assign step     = en && (mode_sel != MODE_HOLD);

  // Galois-form feedback: the outgoing MSB combined with the incoming bit
  // decides whether the polynomial is folded into the shifted value.
  assign crc_fb   = q_q[WIDTH-1] ^ din;

  // Next-state logic. Priority is load over step over idle. Reset is
  // handled in the register process. done defaults low so it can only
  // ever be a single-cycle pulse.
  always_comb begin
    q_d    = q_q;
    pop_d  = pop_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;

    if (load) begin
      q_d   = load_val;
      pop_d = 1'b0;
      cnt_d = '0;
    end else if (step) begin
      case (mode_sel)
        MODE_LEFT: begin
          q_d   = {q_q[WIDTH-2:0], din};
          pop_d = q_q[WIDTH-1];
        end
        MODE_RIGHT: begin
          q_d   = {din, q_q[WIDTH-1:1]};
          pop_d = q_q[0];
        end
        MODE_CRC: begin
          q_d   = {q_q[WIDTH-2:0], 1'b0} ^ (crc_fb ? POLY : '0);
          pop_d = q_q[WIDTH-1];
        end
        default: begin
          q_d   = q_q;
          pop_d = pop_q;
        end
      endcase

      // The frame counter wraps on the last step and flags completion.
      if (cnt_q == LAST_CNT) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset. A reset mid-frame
  // discards the partial frame, so no done pulse is produced.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q    <= INIT;
      pop_q  <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      pop_q  <= pop_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q    = q_q;
  assign pop  = pop_q;
  assign cnt  = cnt_q;
  assign done = done_q;

endmodule
